// File: rtl/fb_fill_ctrl.sv
// fb_fill_ctrl: frame-buffer fill engine and write-port arbiter.
// A fill command sweeps one colour across addresses 0..FB_WORDS-1 while CPU
// stores share the single write port. The fill is starved by at most
// STARVE_MAX consecutive CPU grants.
// Optional build macro: FB_FILL_ABORT_EN adds an abort input that cancels a
// running fill without a done pulse.
module fb_fill_ctrl #(
    parameter int FB_WORDS   = 786432,
    parameter int ADDR_W     = 20,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [31:0]       cmd_color,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    input  logic              cpu_fb_we,
    input  logic [ADDR_W-1:0] cpu_fb_addr,
    input  logic [31:0]       cpu_fb_wdata,
    output logic              cpu_fb_stall,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       fb_wdata,
    input  logic              fb_ready
`ifdef FB_FILL_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);
    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       color_r;
    logic [ADDR_W-1:0] addr_cnt;
    logic [3:0]        starve_cnt;

    logic fill_req;
    logic grant_cpu;
    logic grant_fill;
    logic cpu_xfer;
    logic fill_xfer;
    logic abort_hit;

`ifdef FB_FILL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // The CPU wins unless a pending fill has already been starved STARVE_MAX times.
    assign fill_req     = (state == S_FILL);
    assign grant_cpu    = cpu_fb_we & (~fill_req | (starve_cnt < STARVE_LIM));
    assign grant_fill   = fill_req & ~grant_cpu;
    assign cpu_xfer     = grant_cpu & fb_ready;
    assign fill_xfer    = grant_fill & fb_ready;
    assign fb_we        = cpu_fb_we | fill_req;
    assign cpu_fb_stall = cpu_fb_we & ~cpu_xfer;

    // Write-port address/data mux from the granted source; zero when idle.
    always_comb begin
        fb_addr  = '0;
        fb_wdata = '0;
        if (grant_cpu) begin
            fb_addr  = cpu_fb_addr;
            fb_wdata = cpu_fb_wdata;
        end else if (grant_fill) begin
            fb_addr  = addr_cnt;
            fb_wdata = color_r;
        end
    end

    // Fill sequencer with registered status outputs and the starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            color_r    <= '0;
            addr_cnt   <= '0;
            starve_cnt <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    done       <= 1'b0;
                    starve_cnt <= '0;
                    if (cmd_valid) begin
                        color_r   <= cmd_color;
                        addr_cnt  <= '0;
                        state     <= S_FILL;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (abort_hit) begin
                        // A fill transfer in this cycle still lands at the port.
                        state      <= S_IDLE;
                        addr_cnt   <= '0;
                        starve_cnt <= '0;
                        busy       <= 1'b0;
                        cmd_ready  <= 1'b1;
                    end else if (fill_xfer) begin
                        starve_cnt <= '0;
                        if (addr_cnt == LAST_ADDR) begin
                            // Counter stops on the last word so it never wraps.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end else if (cpu_xfer && (starve_cnt < STARVE_LIM)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    cmd_ready  <= 1'b1;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= S_IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    cmd_ready  <= 1'b1;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// tb_fb_fill_ctrl: scoreboard bench for fb_fill_ctrl with FB_WORDS=16,
// STARVE_MAX=4. Expected port writes are queued by the stimulus and popped
// by a monitor on every write-port transfer.
module tb_fb_fill_ctrl;

    localparam int FB_WORDS   = 16;
    localparam int ADDR_W     = 20;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [31:0]       cmd_color;
    logic              cmd_ready;
    logic              busy;
    logic              done;
    logic              cpu_fb_we;
    logic [ADDR_W-1:0] cpu_fb_addr;
    logic [31:0]       cpu_fb_wdata;
    logic              cpu_fb_stall;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [31:0]       fb_wdata;
    logic              fb_ready;
`ifdef FB_FILL_ABORT_EN
    logic              abort;
`endif

    fb_fill_ctrl #(
        .FB_WORDS  (FB_WORDS),
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_color   (cmd_color),
        .cmd_ready   (cmd_ready),
        .busy        (busy),
        .done        (done),
        .cpu_fb_we   (cpu_fb_we),
        .cpu_fb_addr (cpu_fb_addr),
        .cpu_fb_wdata(cpu_fb_wdata),
        .cpu_fb_stall(cpu_fb_stall),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_ready    (fb_ready)
`ifdef FB_FILL_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    int          total    = 0;
    int          passed   = 0;
    int          done_cnt = 0;
    logic [31:0] mem [0:511];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic push(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_fill(input logic [31:0] color, input int from, input int to);
        for (int w = from; w <= to; w++) push(w, color);
    endtask

    // Monitor: every transfer at the port must match the head of the queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) done_cnt++;
                if (fb_we && fb_ready) begin
                    mem[fb_addr[8:0]] = fb_wdata;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                                 fb_addr, fb_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(fb_addr), 64'(e.addr));
                        check("wr_data", 64'(fb_wdata), 64'(e.data));
                    end
                end
            end
        end
    end

    task automatic start_cmd(input logic [31:0] color);
        cmd_valid = 1'b1;
        cmd_color = color;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Runs the fill cycle by cycle (cycle 1 = first cycle after acceptance)
    // and checks the cycle in which done appears.
    task automatic wait_done(input int exp_lat, input bit toggle, input int cpu_k,
                             input int cpu_a, input logic [31:0] cpu_d,
                             input bit cpu_cont, input string name);
        int k      = 1;
        bit seen   = 1'b0;
        bit ctl_ok = 1'b1;
        int idx    = 0;
        int stalls = 0;
        while (k <= 400 && !seen) begin
            fb_ready     = toggle ? (k % 2 == 1) : 1'b1;
            cpu_fb_we    = 1'b0;
            cpu_fb_addr  = '0;
            cpu_fb_wdata = '0;
            if (cpu_k == k) begin
                cpu_fb_we    = 1'b1;
                cpu_fb_addr  = ADDR_W'(cpu_a);
                cpu_fb_wdata = cpu_d;
            end
            if (cpu_cont && idx < 64) begin
                cpu_fb_we    = 1'b1;
                cpu_fb_addr  = ADDR_W'(256 + idx);
                cpu_fb_wdata = 32'hC0DE0000 + 32'(idx);
            end
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (cmd_ready !== 1'b0 || busy !== 1'b1) ctl_ok = 1'b0;
            if (cpu_cont && cpu_fb_we) begin
                if (cpu_fb_stall) stalls++;
                else idx++;
            end
            if (!seen) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        check({name, "_done_cycle"}, 64'(k), 64'(exp_lat));
        check({name, "_busy_ctl"}, 64'(ctl_ok), 64'd1);
        check({name, "_busy_in_done"}, 64'(busy), 64'd1);
        if (cpu_cont) check({name, "_stalls"}, 64'(stalls), 64'd15);
        @(posedge clk);
        #1;
        cpu_fb_we = 1'b0;
        fb_ready  = 1'b1;
        @(negedge clk);
        check({name, "_done_once"}, 64'(done), 64'd0);
        check({name, "_ready_back"}, 64'(cmd_ready), 64'd1);
        check({name, "_busy_clr"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int saved;
        int bad;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_color    = '0;
        cpu_fb_we    = 1'b0;
        cpu_fb_addr  = '0;
        cpu_fb_wdata = '0;
        fb_ready     = 1'b1;
`ifdef FB_FILL_ABORT_EN
        abort        = 1'b0;
`endif
        for (int i = 0; i < 512; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_fb_we", 64'(fb_we), 64'd0);
        check("rst_fb_addr", 64'(fb_addr), 64'd0);
        check("rst_fb_wdata", 64'(fb_wdata), 64'd0);
        check("rst_stall", 64'(cpu_fb_stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic fill: 16 words on consecutive cycles, done in cycle 17.
        push_fill(32'h00ff0000, 0, 15);
        start_cmd(32'h00ff0000);
        wait_done(17, 1'b0, 0, 0, 0, 1'b0, "basic");

        // Backpressure toggling 1,0,1,0: word w lands in cycle 2w+1, done in cycle 32.
        push_fill(32'hA5A5A5A5, 0, 15);
        start_cmd(32'hA5A5A5A5);
        wait_done(32, 1'b1, 0, 0, 0, 1'b0, "bp");

        // Continuous CPU stores: CPU x4 then fill x1; fill w in cycle 5(w+1), done in 81.
        for (int w = 0; w < 16; w++) begin
            for (int j = 0; j < 4; j++) push(256 + 4 * w + j, 32'hC0DE0000 + 32'(4 * w + j));
            push(w, 32'h0000CAFE);
        end
        start_cmd(32'h0000CAFE);
        wait_done(81, 1'b0, 0, 0, 0, 1'b1, "arb");

        // CPU store to addr 3 ahead of the sweep: fill overwrites it.
        push(3, 32'h12345678);
        push_fill(32'h00112233, 0, 15);
        start_cmd(32'h00112233);
        wait_done(18, 1'b0, 1, 3, 32'h12345678, 1'b0, "st_pre");
        check("st_pre_mem3", 64'(mem[3]), 64'h00112233);

        // Same store after the sweep passed addr 3: CPU data survives.
        push_fill(32'h00445566, 0, 6);
        push(3, 32'h12345678);
        push_fill(32'h00445566, 7, 15);
        start_cmd(32'h00445566);
        wait_done(18, 1'b0, 8, 3, 32'h12345678, 1'b0, "st_post");
        check("st_post_mem3", 64'(mem[3]), 64'h12345678);

        // Command held during a fill is only taken once the engine is idle.
        push_fill(32'h0055AA00, 0, 15);
        push_fill(32'h00000f0f, 0, 15);
        cmd_valid = 1'b1;
        cmd_color = 32'h0055AA00;
        @(posedge clk);
        #1;
        cmd_color = 32'h00000f0f;
        wait_done(17, 1'b0, 0, 0, 0, 1'b0, "busy1");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(17, 1'b0, 0, 0, 0, 1'b0, "busy2");
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 32'h00000f0f) bad++;
        check("busy2_all_words", 64'(bad), 64'd0);

        // Asynchronous reset when addr_cnt reaches 7.
        saved = done_cnt;
        push_fill(32'h00000077, 0, 6);
        start_cmd(32'h00000077);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_fb_we", 64'(fb_we), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'(saved));

`ifdef FB_FILL_ABORT_EN
        // Abort when addr_cnt is 7: word 7 still lands, nothing above it.
        saved = done_cnt;
        @(posedge clk);
        #1;
        push_fill(32'h00000099, 0, 7);
        start_cmd(32'h00000099);
        repeat (7) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_fb_we", 64'(fb_we), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (20) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(saved));
`endif

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'd7);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fb_fill_ctrl.md
# fb_fill_ctrl

Hardware frame-buffer fill engine and write-port arbiter. Sits between the CPU's memory-mapped frame-buffer store path and the single frame-buffer write port. It replaces the software fill loop (one store per pixel word) with a command-driven sweep that writes one colour to every word. CPU stores to the frame buffer share the port, with bounded starvation of the fill.

## Interface
Parameters:
- FB_WORDS, 786432 — words per frame; sweep covers addresses 0..FB_WORDS-1
- ADDR_W, 20 — frame-buffer word-address width; FB_WORDS ≤ 2^ADDR_W
- STARVE_MAX, 4 — max consecutive CPU grants while a fill is pending; range 1..15

Ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  fill command request
- cmd_color  in  32  fill word
- cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready
- busy  out  1  fill in progress (FILL or DONE state)
- done  out  1  one-cycle pulse after last fill word transfers
- cpu_fb_we  in  1  CPU frame-buffer store request
- cpu_fb_addr  in  ADDR_W  CPU store word address
- cpu_fb_wdata  in  32  CPU store data
- cpu_fb_stall  out  1  CPU store not accepted this cycle; CPU holds request
- fb_we  out  1  frame-buffer write strobe
- fb_addr  out  ADDR_W  frame-buffer word address
- fb_wdata  out  32  frame-buffer write data
- fb_ready  in  1  frame buffer accepts write; transfer = fb_we & fb_ready
- abort  in  1  (only with FB_FILL_ABORT_EN) cancel running fill

## Operation
- States: IDLE, FILL, DONE. Reset → IDLE; color_r=0, addr_cnt=0, starve_cnt=0, done=0, busy=0, cmd_ready=1.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_color into color_r, addr_cnt←0, starve_cnt←0, → FILL.
- FILL: fill_req=1 with address addr_cnt and data color_r.
- Grant: grant_cpu = cpu_fb_we & (!fill_req | starve_cnt < STARVE_MAX); grant_fill = fill_req & !grant_cpu.
- fb_we = cpu_fb_we | fill_req. fb_addr/fb_wdata come from the granted source; they are 0 when fb_we=0.
- cpu_fb_stall = cpu_fb_we & !(grant_cpu & fb_ready).
- starve_cnt increments on a CPU transfer while fill_req=1, saturating at STARVE_MAX. It clears on a fill transfer and is held 0 outside FILL.
- On a fill transfer: addr_cnt←addr_cnt+1. If addr_cnt==FB_WORDS-1, → DONE. addr_cnt never wraps.
- DONE: done=1 for exactly one cycle, then → IDLE. The fill does not request in DONE.
- Commands arriving while busy are not accepted (cmd_ready=0). There is no queue.
- Ordering: a CPU store to an address not yet swept is overwritten by the fill. The last writer wins, and this is intended behaviour.

## Timing
- Arbitration and outputs are combinational from registered state and CPU inputs. There is no added latency on the CPU path.
- The command is accepted on edge N. The first fill fb_we is asserted in cycle N+1.
- With no CPU traffic and fb_ready=1, fill takes FB_WORDS cycles. done is high in cycle N+1+FB_WORDS.
- When fb_ready=0, all state holds. The starve counter does not advance without a transfer.
- Under continuous CPU stores with fb_ready=1, the pattern is STARVE_MAX CPU transfers followed by 1 fill transfer, repeating.
- Asynchronous rst mid-fill returns to IDLE immediately, with no done pulse. Outputs take reset values within the same cycle.

## Configuration
- FB_FILL_ABORT_EN defined:
  - Adds the abort port.
  - abort=1 in FILL → IDLE on the next edge; no done pulse; addr_cnt←0.
  - abort in IDLE or DONE is ignored.
  - Any fill transfer occurring in the abort cycle still completes at the port.
- FB_FILL_ABORT_EN undefined: no abort port, and a fill always runs to completion or reset.

## Test plan
- Basic fill, FB_WORDS=16, fb_ready=1, cmd_color=0x00ff0000 → addresses 0..15 each written with 0x00ff0000 on consecutive cycles; done pulse once; cmd_ready returns 1.
- Backpressure: toggle fb_ready 1,0,1,0… → each address written exactly once, in order; addr_cnt holds during fb_ready=0; done after 32 cycles.
- Arbitration, STARVE_MAX=4, CPU stores every cycle during fill → grant pattern CPU×4, fill×1; cpu_fb_stall high only in fill-grant cycles; fill completes.
- CPU store to addr 3 before the sweep reaches it, data 0x12345678 → final addr 3 = fill color. The same store after the sweep passed → final value 0x12345678.
- Command while busy: cmd_valid held during fill with a second color 0x00000f0f → not accepted until IDLE, then a second sweep writes 0x00000f0f everywhere.
- Reset mid-fill at addr_cnt=7 → busy=0, fb_we=0 when no CPU request, cmd_ready=1, no done. With FB_FILL_ABORT_EN, abort at addr_cnt=7 → same result, and no address ≥8 is written.
